// File: rtl/icache_pkg.sv
// Shared types and widths for the direct-mapped instruction cache.
package icache_pkg;

    localparam int ADDR_W_DEF = 10;
    localparam int LINES_DEF  = 8;
    localparam int OFF_W      = 2;
    localparam int IDX_W      = $clog2(LINES_DEF);
    localparam int TAG_W      = ADDR_W_DEF - 4 - IDX_W;

    typedef logic [127:0] line_t;

    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE     = 2'd0;
    localparam state_t ST_MEM_READ = 2'd1;
    localparam state_t ST_UPDATE   = 2'd2;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/icache_array.sv
// Valid/tag/data storage: combinational read port, synchronous write port.
module icache_array
    import icache_pkg::*;
#(
    parameter int LINES = LINES_DEF,
    parameter int TW    = TAG_W,
    localparam int IW   = $clog2(LINES)
) (
    input  logic          CLK,
    input  logic          RESET,
    input  logic [IW-1:0] rd_index,
    output logic          rd_valid,
    output logic [TW-1:0] rd_tag,
    output line_t         rd_line,
    input  logic          we,
    input  logic [IW-1:0] wr_index,
    input  logic [TW-1:0] wr_tag,
    input  line_t         wr_line
);

    logic [LINES-1:0] valid;
    logic [TW-1:0]    tags [LINES];
    line_t            data [LINES];

    always_ff @(posedge CLK) begin
        if (!RESET)
            valid <= '0;
        else if (we)
            valid[wr_index] <= 1'b1;
    end

    // tag/data are qualified by valid, so they need no reset
    always_ff @(posedge CLK) begin
        if (we) begin
            tags[wr_index] <= wr_tag;
            data[wr_index] <= wr_line;
        end
    end

    assign rd_valid = valid[rd_index];
    assign rd_tag   = tags[rd_index];
    assign rd_line  = data[rd_index];

endmodule

// File: rtl/icache_fetch.sv
// Direct-mapped read-only instruction cache with blocking line refill.
// Define ICACHE_STATS_EN to add saturating HIT_COUNT/MISS_COUNT outputs.
module icache_fetch
    import icache_pkg::*;
#(
    parameter int ADDR_W         = ADDR_W_DEF,
    parameter int LINES          = LINES_DEF,
    parameter int WORDS_PER_LINE = 4
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic [31:0]       ADDRESS,
    output logic [31:0]       INSTRUCTION,
    output logic              BUSYWAIT,
    output logic              MEM_READ,
    output logic [ADDR_W-5:0] MEM_ADDRESS,
    input  line_t             MEM_READDATA,
`ifdef ICACHE_STATS_EN
    output logic [15:0]       HIT_COUNT,
    output logic [15:0]       MISS_COUNT,
`endif
    input  logic              MEM_BUSYWAIT
);

    localparam int OW = $clog2(WORDS_PER_LINE);
    localparam int IW = $clog2(LINES);
    localparam int TW = ADDR_W - 4 - IW;

    logic [OW-1:0] off;
    logic [IW-1:0] idx;
    logic [TW-1:0] tag;
    logic [IW-1:0] miss_idx;
    logic [TW-1:0] miss_tag;
    state_t        state;
    state_t        state_n;
    logic          rd_valid;
    logic [TW-1:0] rd_tag;
    line_t         rd_line;
    logic          hit;
    logic          fill;
    logic          unused_bits;

    assign off = ADDRESS[2 +: OW];
    assign idx = ADDRESS[4 +: IW];
    assign tag = ADDRESS[4 + IW +: TW];
    assign unused_bits = ^{ADDRESS[31:ADDR_W], ADDRESS[1:0]};

    icache_array #(
        .LINES (LINES),
        .TW    (TW)
    ) u_array (
        .CLK      (CLK),
        .RESET    (RESET),
        .rd_index (idx),
        .rd_valid (rd_valid),
        .rd_tag   (rd_tag),
        .rd_line  (rd_line),
        .we       (fill),
        .wr_index (miss_idx),
        .wr_tag   (miss_tag),
        .wr_line  (MEM_READDATA)
    );

    // outputs stay quiet while reset is held, even before state settles
    assign hit = RESET && (state == ST_IDLE)
                 && rd_valid && (rd_tag == tag);
    assign fill = RESET && (state == ST_MEM_READ) && !MEM_BUSYWAIT;

    assign INSTRUCTION = hit ? rd_line[{off, 5'd0} +: 32] : '0;
    assign BUSYWAIT    = RESET && !hit;
    assign MEM_READ    = RESET && (state == ST_MEM_READ);
    assign MEM_ADDRESS = MEM_READ ? {miss_tag, miss_idx} : '0;

    always_comb begin
        state_n = state;
        unique case (1'b1)
            (state == ST_IDLE):     if (!hit) state_n = ST_MEM_READ;
            (state == ST_MEM_READ): if (!MEM_BUSYWAIT) state_n = ST_UPDATE;
            default:                state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            state    <= ST_IDLE;
            miss_idx <= '0;
            miss_tag <= '0;
        end else begin
            state <= state_n;
            if (state == ST_IDLE && !hit) begin
                miss_idx <= idx;
                miss_tag <= tag;
            end
        end
    end

`ifdef ICACHE_STATS_EN
    logic [15:0] hit_cnt;
    logic [15:0] miss_cnt;

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            hit_cnt  <= '0;
            miss_cnt <= '0;
        end else begin
            if (hit)
                hit_cnt <= sat_inc(hit_cnt);
            if (state == ST_IDLE && !hit)
                miss_cnt <= sat_inc(miss_cnt);
        end
    end

    assign HIT_COUNT  = hit_cnt;
    assign MISS_COUNT = miss_cnt;
`endif

endmodule

// File: tb/tb_icache_fetch.sv
// Scoreboard bench for icache_fetch with a variable-latency memory model.
module tb_icache_fetch;
    import icache_pkg::*;

    logic        CLK = 1'b0;
    logic        RESET;
    logic [31:0] ADDRESS;
    logic [31:0] INSTRUCTION;
    logic        BUSYWAIT;
    logic        MEM_READ;
    logic [5:0]  MEM_ADDRESS;
    line_t       MEM_READDATA;
    logic        MEM_BUSYWAIT;
`ifdef ICACHE_STATS_EN
    logic [15:0] HIT_COUNT;
    logic [15:0] MISS_COUNT;
`endif

    icache_fetch dut (
        .CLK          (CLK),
        .RESET        (RESET),
        .ADDRESS      (ADDRESS),
        .INSTRUCTION  (INSTRUCTION),
        .BUSYWAIT     (BUSYWAIT),
        .MEM_READ     (MEM_READ),
        .MEM_ADDRESS  (MEM_ADDRESS),
        .MEM_READDATA (MEM_READDATA),
`ifdef ICACHE_STATS_EN
        .HIT_COUNT    (HIT_COUNT),
        .MISS_COUNT   (MISS_COUNT),
`endif
        .MEM_BUSYWAIT (MEM_BUSYWAIT)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [31:0] instr;
        int          stall;
    } exp_t;

    exp_t        q[$];
    logic [31:0] refills[$];
    int          n_pass = 0;
    int          n_total = 0;
    int          issued = 0;
    int          served = 0;
    int          stall_cnt = 0;
    int          lat = 5;
    int          mcnt = 0;
    logic        prev_rd = 1'b0;

    task automatic check(input string name,
                         input logic [31:0] act,
                         input logic [31:0] exp);
        n_total++;
        if (act === exp)
            n_pass++;
        else
            $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // memory word for byte address a is 0x1000_0000 + a
    always_comb begin
        MEM_READDATA = '0;
        for (int k = 0; k < 4; k++)
            MEM_READDATA[32*k +: 32] =
                32'h1000_0000 + {22'd0, MEM_ADDRESS, 4'd0} + 32'(4 * k);
        MEM_BUSYWAIT = !(MEM_READ && (mcnt >= lat - 1));
    end

    always @(posedge CLK)
        mcnt <= MEM_READ ? mcnt + 1 : 0;

    always @(negedge CLK) begin
        exp_t e;
        if (RESET && MEM_READ && !prev_rd)
            refills.push_back(32'(MEM_ADDRESS));
        prev_rd = MEM_READ;
        if (RESET && served != issued) begin
            if (!MEM_READ)
                check("memaddr_zero", 32'(MEM_ADDRESS), 32'd0);
            if (BUSYWAIT) begin
                stall_cnt++;
            end else if (q.size() == 0) begin
                check("scoreboard_empty", 32'd0, 32'd1);
                served++;
            end else begin
                e = q.pop_front();
                check("instr", INSTRUCTION, e.instr);
                if (e.stall >= 0)
                    check("stall", 32'(stall_cnt), 32'(e.stall));
                stall_cnt = 0;
                served++;
            end
        end
    end

    task automatic wait_served();
        for (int i = 0; i < 60 && served != issued; i++)
            @(posedge CLK);
        if (served != issued) begin
            $display("FAIL timeout: served %0d expected %0d", served, issued);
            $fatal(1, "no response");
        end
    endtask

    // called at a rising edge; returns at a rising edge
    task automatic fetch(input logic [31:0] a, input int stall);
        #1;
        RESET = 1'b1;
        ADDRESS = a;
        q.push_back('{32'h1000_0000 + (a & 32'h3FC), stall});
        issued++;
        wait_served();
    endtask

    task automatic expect_refill(input string name, input logic [31:0] blk);
        if (refills.size() == 0)
            check(name, 32'hFFFF_FFFF, blk);
        else
            check(name, refills.pop_front(), blk);
    endtask

    initial begin
        RESET = 1'b0;
        ADDRESS = 32'h0;
        @(posedge CLK);
        @(negedge CLK);
        check("rst_busywait", 32'(BUSYWAIT), 32'd0);
        check("rst_memread", 32'(MEM_READ), 32'd0);
        check("rst_instr", INSTRUCTION, 32'd0);
        @(posedge CLK);

        // cold miss, latency 5, then same-line hits
        lat = 5;
        fetch(32'h000, 7);
        expect_refill("t1_refill", 32'h00);
        fetch(32'h004, 0);
        fetch(32'h008, 0);
        fetch(32'h00C, 0);
        check("t2_no_refill", 32'(refills.size()), 32'd0);
`ifdef ICACHE_STATS_EN
        #1;
        check("stats_miss", 32'(MISS_COUNT), 32'd1);
        check("stats_hit", 32'(HIT_COUNT), 32'd4);
`endif

        // conflict on index 0 with single-cycle memory, then aliasing
        lat = 1;
        fetch(32'h080, 3);
        expect_refill("t3_refill_a", 32'h08);
        fetch(32'h000, 3);
        expect_refill("t3_refill_b", 32'h00);
        fetch(32'h004, 0);
        fetch(32'hFFFF_FC0C, 0);

        // reset in the third of five MEM_READ cycles
        lat = 5;
        #1 ADDRESS = 32'h100;
        repeat (3) @(posedge CLK);
        #1 RESET = 1'b0;
        @(negedge CLK);
        check("t4_memread", 32'(MEM_READ), 32'd0);
        check("t4_busywait", 32'(BUSYWAIT), 32'd0);
        check("t4_instr", INSTRUCTION, 32'd0);
        expect_refill("t4_refill", 32'h10);
        @(posedge CLK);
        fetch(32'h000, 7);
        expect_refill("t4_refill2", 32'h00);

        // address moves while a refill is in flight
        #1 ADDRESS = 32'h010;
        repeat (2) @(posedge CLK);
        #1 ADDRESS = 32'h020;
        q.push_back('{32'h1000_0020, -1});
        issued++;
        wait_served();
        expect_refill("t5_refill_a", 32'h01);
        expect_refill("t5_refill_b", 32'h02);
        fetch(32'h014, 0);
        fetch(32'h028, 0);
        check("t5_no_refill", 32'(refills.size()), 32'd0);

`ifdef ICACHE_STATS_EN
        #1 ADDRESS = 32'h004;
        repeat (70000) @(posedge CLK);
        #1;
        check("stats_hit_sat", 32'(HIT_COUNT), 32'h0000_FFFF);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
